// File: rtl/axis_msg_tx.sv
// AXI-Stream message transmitter: fetches 2*DATA_W words and serialises them as framed beats.
// Optional message counter is built when AXIS_TX_MSG_COUNT_EN is defined.
module axis_msg_tx #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_msg_len,
  input  logic                i_downsizing,
  output logic                o_busy,
  input  logic                i_in_valid,
  input  logic [2*DATA_W-1:0] i_in_data,
  output logic                o_in_ready,
  output logic                o_m_tvalid,
  output logic [DATA_W-1:0]   o_m_tdata,
  output logic                o_m_tlast,
  input  logic                i_m_tready,
  output logic                o_msg_done
`ifdef AXIS_TX_MSG_COUNT_EN
  ,
  input  logic                i_clear_msg_count,
  output logic [15:0]         o_msg_count
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

  state_e              r_state;
  logic [LEN_W-1:0]    r_words_left;
  logic                r_down;
  logic                r_half;
  logic [2*DATA_W-1:0] r_word;
  logic                r_busy;
  logic                r_tvalid;
  logic                r_msg_done;

  logic w_word_final;
  logic w_last_word;
  logic w_load;

  assign w_word_final = !r_down || r_half;
  assign w_last_word  = (r_words_left == '0);

  // In SEND the next word may be taken in the same cycle as the word-final handshake.
  assign o_in_ready = (r_state == StFetch) ||
                      ((r_state == StSend) && w_word_final && i_m_tready && !w_last_word);
  assign w_load     = i_in_valid && o_in_ready;

  assign o_busy     = r_busy;
  assign o_m_tvalid = r_tvalid;
  assign o_m_tdata  = r_half ? r_word[2*DATA_W-1:DATA_W] : r_word[DATA_W-1:0];
  assign o_m_tlast  = r_tvalid && w_word_final && w_last_word;
  assign o_msg_done = r_msg_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_words_left <= '0;
      r_down       <= 1'b0;
      r_half       <= 1'b0;
      r_word       <= '0;
      r_busy       <= 1'b0;
      r_tvalid     <= 1'b0;
      r_msg_done   <= 1'b0;
    end else begin
      r_msg_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_words_left <= i_msg_len;
            r_down       <= i_downsizing;
            r_busy       <= 1'b1;
            r_state      <= StFetch;
          end
        end
        StFetch: begin
          if (w_load) begin
            r_word   <= i_in_data;
            r_half   <= 1'b0;
            r_tvalid <= 1'b1;
            r_state  <= StSend;
          end
        end
        StSend: begin
          if (i_m_tready) begin
            if (!w_word_final) begin
              r_half <= 1'b1;
            end else if (w_last_word) begin
              r_tvalid   <= 1'b0;
              r_busy     <= 1'b0;
              r_msg_done <= 1'b1;
              r_state    <= StIdle;
            end else begin
              r_words_left <= r_words_left - LEN_W'(1);
              if (w_load) begin
                r_word <= i_in_data;
                r_half <= 1'b0;
              end else begin
                r_tvalid <= 1'b0;
                r_state  <= StFetch;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef AXIS_TX_MSG_COUNT_EN
  logic [15:0] r_msg_count;

  // Clear wins over a coincident increment; the count wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msg_count <= '0;
    end else if (i_clear_msg_count) begin
      r_msg_count <= '0;
    end else if (r_msg_done) begin
      r_msg_count <= r_msg_count + 16'd1;
    end
  end

  assign o_msg_count = r_msg_count;
`endif

endmodule

// File: tb/tb_axis_msg_tx.sv
// Self-checking bench for axis_msg_tx: randomised load/stream handshakes against a beat-queue model.
module tb_axis_msg_tx;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [LW-1:0] i_msg_len;
  logic          i_downsizing;
  logic          o_busy;
  logic          i_in_valid;
  logic [2*DW-1:0] i_in_data;
  logic          o_in_ready;
  logic          o_m_tvalid;
  logic [DW-1:0] o_m_tdata;
  logic          o_m_tlast;
  logic          i_m_tready;
  logic          o_msg_done;
`ifdef AXIS_TX_MSG_COUNT_EN
  logic          i_clear_msg_count;
  logic [15:0]   o_msg_count;
  bit            clr_on_done = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [2*DW-1:0] msg_words[$];

  always #5 clk = ~clk;

  axis_msg_tx #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_msg_len    (i_msg_len),
    .i_downsizing (i_downsizing),
    .o_busy       (o_busy),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .o_in_ready   (o_in_ready),
    .o_m_tvalid   (o_m_tvalid),
    .o_m_tdata    (o_m_tdata),
    .o_m_tlast    (o_m_tlast),
    .i_m_tready   (i_m_tready),
    .o_msg_done   (o_msg_done)
`ifdef AXIS_TX_MSG_COUNT_EN
    ,
    .i_clear_msg_count (i_clear_msg_count),
    .o_msg_count       (o_msg_count)
`endif
  );

  // tready_pct < 0 selects the fixed 1,0,0,1 ready pattern.
  task automatic run_msg(input int len, input bit down, input int tready_pct, input int valid_pct,
                         input bit mid_start, input bit full, input string name);
    logic [DW-1:0] exp_d[$];
    bit            exp_l[$];
    int widx = 0, cyc = 0, first = -1, lastc = -1, dones = 0, nbeats;
    bit pend = 1'b0, done = 1'b0;
    logic [DW-1:0] pd;
    logic pl;
    for (int i = 0; i <= len; i++) begin
      exp_d.push_back(msg_words[i][DW-1:0]);
      exp_l.push_back(!down && (i == len));
      if (down) begin
        exp_d.push_back(msg_words[i][2*DW-1:DW]);
        exp_l.push_back(i == len);
      end
    end
    nbeats = exp_d.size();
    while (!done && cyc < 3000) begin
      i_start      = (cyc == 0) || (mid_start && lastc < 0 && $urandom_range(3) == 0);
      i_msg_len    = (cyc == 0) ? LW'(len) : LW'($urandom);
      i_downsizing = (cyc == 0) ? down : 1'($urandom);
      i_in_valid   = $urandom_range(99) < valid_pct;
      i_in_data    = (i_in_valid && widx <= len) ? msg_words[widx] : {$urandom, $urandom};
      i_m_tready   = (tready_pct < 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3))
                                      : ($urandom_range(99) < tready_pct);
`ifdef AXIS_TX_MSG_COUNT_EN
      i_clear_msg_count = clr_on_done && o_msg_done;
`endif
      #1;
      if (cyc == 0) begin
        n_cmp++;
        if (o_busy !== 1'b0) begin
          n_err++; $display("FAIL %s idle_busy: got %b want 0", name, o_busy);
        end
      end
      if (cyc == 1) begin
        n_cmp++;
        if (o_busy !== 1'b1 || o_in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL %s start_latency: busy=%b in_ready=%b want 1 1", name, o_busy, o_in_ready);
        end
      end
      if (pend) begin
        n_cmp++;
        if (o_m_tvalid !== 1'b1 || o_m_tdata !== pd || o_m_tlast !== pl) begin
          n_err++;
          $display("FAIL %s stall_hold: valid=%b data=%h last=%b want 1 %h %b",
                   name, o_m_tvalid, o_m_tdata, o_m_tlast, pd, pl);
        end
      end
      if (o_m_tvalid && !i_m_tready) begin
        n_cmp++;
        if (o_in_ready !== 1'b0) begin
          n_err++; $display("FAIL %s in_ready_stall: got %b want 0", name, o_in_ready);
        end
      end
      if (o_msg_done === 1'b1) begin
        dones++;
        done = 1'b1;
        n_cmp++;
        if (lastc != cyc - 1) begin
          n_err++; $display("FAIL %s done_timing: got cycle %0d want %0d", name, cyc, lastc + 1);
        end
      end
      if (o_m_tvalid === 1'b1 && i_m_tready) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_err++; $display("FAIL %s extra_beat: got %h want none", name, o_m_tdata);
        end else begin
          if (o_m_tdata !== exp_d[0] || o_m_tlast !== exp_l[0]) begin
            n_err++;
            $display("FAIL %s beat: data=%h last=%b want %h %b",
                     name, o_m_tdata, o_m_tlast, exp_d[0], exp_l[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
          if (first < 0) first = cyc;
          if (exp_d.size() == 0) lastc = cyc;
        end
      end
      pend = o_m_tvalid && !i_m_tready;
      pd   = o_m_tdata;
      pl   = o_m_tlast;
      if (i_in_valid && o_in_ready) widx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    i_start    = 1'b0;
    i_in_valid = 1'b0;
`ifdef AXIS_TX_MSG_COUNT_EN
    i_clear_msg_count = 1'b0;
`endif
    #1;
    n_cmp++;
    if (!done || exp_d.size() != 0 || dones != 1) begin
      n_err++;
      $display("FAIL %s completion: done=%0d left=%0d pulses=%0d want 1 0 1",
               name, done, exp_d.size(), dones);
    end
    n_cmp++;
    if (widx != len + 1) begin
      n_err++; $display("FAIL %s fetch_count: got %0d want %0d", name, widx, len + 1);
    end
    n_cmp++;
    if (o_busy !== 1'b0 || o_msg_done !== 1'b0 || o_m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: busy=%b done=%b valid=%b want 0 0 0",
               name, o_busy, o_msg_done, o_m_tvalid);
    end
    if (full) begin
      n_cmp++;
      if (first != 2 || lastc != first + nbeats - 1) begin
        n_err++;
        $display("FAIL %s throughput: first=%0d last=%0d want 2 %0d", name, first, lastc,
                 1 + nbeats);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (o_busy !== 1'b0 || o_in_ready !== 1'b0 || o_m_tvalid !== 1'b0 || o_m_tdata !== '0 ||
        o_m_tlast !== 1'b0 || o_msg_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: busy=%b rdy=%b vld=%b data=%h last=%b done=%b want all 0",
               o_busy, o_in_ready, o_m_tvalid, o_m_tdata, o_m_tlast, o_msg_done);
    end
`ifdef AXIS_TX_MSG_COUNT_EN
    n_cmp++;
    if (o_msg_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", o_msg_count);
    end
`endif
  endtask

  task automatic test_min_msg();
    msg_words = {64'h0000_0000_DEAD_BEEF};
    run_msg(0, 1'b0, 100, 100, 1'b0, 1'b1, "min_msg");
  endtask

  task automatic test_downsize();
    msg_words = {64'h1111_1111_0000_0000, 64'h3333_3333_2222_2222, 64'h5555_5555_4444_4444};
    run_msg(2, 1'b1, 100, 100, 1'b0, 1'b1, "downsize");
  endtask

  task automatic test_backpressure();
    msg_words = {64'h1111_1111_0000_0000, 64'h3333_3333_2222_2222, 64'h5555_5555_4444_4444};
    run_msg(2, 1'b1, -1, 100, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_mid_start();
    msg_words = {};
    for (int i = 0; i < 4; i++) msg_words.push_back({$urandom, $urandom});
    run_msg(3, 1'b0, 60, 70, 1'b1, 1'b0, "mid_start");
  endtask

  task automatic test_back_to_back();
    msg_words = {};
    for (int i = 0; i < 6; i++) msg_words.push_back({$urandom, $urandom});
    run_msg(5, 1'b0, 100, 100, 1'b0, 1'b1, "back_to_back");
  endtask

  task automatic test_random();
    for (int m = 0; m < 20; m++) begin
      int len = (m % 5 == 4) ? int'($urandom_range(40)) : int'($urandom_range(5));
      msg_words = {};
      for (int i = 0; i <= len; i++) msg_words.push_back({$urandom, $urandom});
      run_msg(len, 1'($urandom), int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
              1'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_async_reset();
    i_msg_len = 8'd1; i_downsizing = 1'b1; i_start = 1'b1;
    i_in_valid = 1'b1; i_in_data = 64'hBBBB_BBBB_AAAA_AAAA; i_m_tready = 1'b0;
    @(posedge clk); #1; i_start = 1'b0;
    @(posedge clk); #1; i_m_tready = 1'b1;
    @(posedge clk); #1; i_m_tready = 1'b0; i_in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (o_m_tvalid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b0 || o_msg_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: vld=%b busy=%b rdy=%b done=%b want 0 0 0 0",
               o_m_tvalid, o_busy, o_in_ready, o_msg_done);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (o_busy !== 1'b0 || o_msg_done !== 1'b0) begin
      n_err++; $display("FAIL reset_release: busy=%b done=%b want 0 0", o_busy, o_msg_done);
    end
    msg_words = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    run_msg(1, 1'b1, 100, 100, 1'b0, 1'b1, "after_reset");
  endtask

`ifdef AXIS_TX_MSG_COUNT_EN
  task automatic test_msg_count();
    i_clear_msg_count = 1'b1;
    @(posedge clk); #1;
    i_clear_msg_count = 1'b0;
    for (int m = 0; m < 3; m++) begin
      msg_words = {{$urandom, $urandom}};
      run_msg(0, 1'b0, 100, 100, 1'b0, 1'b0, "count");
    end
    n_cmp++;
    if (o_msg_count !== 16'd3) begin
      n_err++; $display("FAIL msg_count: got %0d want 3", o_msg_count);
    end
    clr_on_done = 1'b1;
    msg_words = {{$urandom, $urandom}};
    run_msg(0, 1'b0, 100, 100, 1'b0, 1'b0, "count_clear");
    clr_on_done = 1'b0;
    n_cmp++;
    if (o_msg_count !== 16'd0) begin
      n_err++; $display("FAIL msg_count_clear: got %0d want 0", o_msg_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    i_start = 1'b0; i_msg_len = '0; i_downsizing = 1'b0;
    i_in_valid = 1'b0; i_in_data = '0; i_m_tready = 1'b0;
`ifdef AXIS_TX_MSG_COUNT_EN
    i_clear_msg_count = 1'b0;
`endif
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_min_msg();
    test_downsize();
    test_backpressure();
    test_mid_start();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef AXIS_TX_MSG_COUNT_EN
    test_msg_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
